dsd_cic_decimator: RTL and testbench
====================================

# dsd_cic_decimator

Converts a 1-bit DSD stream back into parallel signed PCM words. It is the inverse path of the PCM-to-DSD delta-sigma modulator chain. An order-N CIC (Hogenauer) decimator runs at the DSD bit clock and produces one PCM word every R accepted DSD bits. The output is saturated and left-aligned to PCM_Bit_Length. The block feeds PCM-side consumers (monitoring, loop-back verification, DSD input path).

## Interface
- PCM_Bit_Length, 32: output PCM word width in bits.
- CIC_ORDER, 4: number of integrator and comb stages (N), 1..6.
- DECIM_LOG2, 6: log2 of decimation ratio; R = 2^DECIM_LOG2.
- Legality: CIC_ORDER*DECIM_LOG2 ≤ PCM_Bit_Length-1, otherwise elaboration error.
- BCLK_I  in  1  DSD bit clock; all logic on rising edge.
- NRST_I  in  1  reset; one clock; reset is asynchronous and active-low.
- DSD_I  in  1  DSD bit; 1 → +1, 0 → −1.
- DSD_EN_I  in  1  bit strobe; DSD_I accepted on edges where high; may be held high continuously.
- PCM_O  out  PCM_Bit_Length  signed PCM sample, held between strobes.
- PCM_VALID_O  out  1  one-cycle pulse when PCM_O updates.

## Operation
- G = CIC_ORDER*DECIM_LOG2. Internal width W = G+2 bits, two's complement, modular (wrapping) arithmetic in all integrators and combs.
- Integrators: on an accepted bit, I1 += x (x = ±1 sign-extended to W), Ik += I(k-1) for k = 2..N. All stages update on the same edge using the pre-edge values.
- Decimation counter: DECIM_LOG2 bits, increments per accepted bit, wraps R-1 → 0. The accept at count R-1 raises dec_stb on the next cycle.
- Decimation register D captures IN when dec_stb is high.
- Comb pipeline: stage k computes Ck = C(k-1) − C(k-1)_delayed, registered. Each stage has its own delay register and valid bit. A stage advances only when its input valid is high. Overlapping samples are legal but never occur, because R ≥ 2 bounds the input rate.
- Output stage: clamp the comb result to ±(2^G − 1). Shift left by PCM_Bit_Length−1−G and register into PCM_O.
- Warm-up: a 3-bit counter suppresses PCM_VALID_O for the first N comb outputs after reset. PCM_O still updates internally but is held at 0 until warm-up ends.
- Reset (asynchronous assert, synchronous release by system): all integrators, combs, delays, counters and valids go to 0. PCM_O = 0, PCM_VALID_O = 0.
- Reset mid-operation discards any in-flight sample. No PCM_VALID_O pulse is emitted for a partially accumulated window.

## Timing
- Edge e0 accepts the R-th bit of a window and updates the integrators.
- Edge e0+1 captures the value into D.
- Edges e0+2 .. e0+N+1 run comb stages 1..N.
- Edge e0+N+2 registers the output. PCM_VALID_O is high during the following cycle.
- Latency from the R-th accepted bit to PCM_VALID_O is N+2 clock cycles, independent of DSD_EN_I after e0.
- Gaps in DSD_EN_I stall the integrators and counter only. The pipeline continues draining.
- The first PCM_VALID_O follows the (N+1)·R-th accepted bit after reset.
- PCM_VALID_O pulses are spaced ≥ R cycles apart. They are never two cycles wide.

## Structure
- Shared package dsd_pcm_pkg holds:
  - the width function cic_width(N, L) = N*L+2;
  - the DSD mapping constants DSD_POS = +1 and DSD_NEG = −1;
  - the DSD silence pattern constant 8'h69, shared with the modulator-side benches.
- One sub-module, cic_comb_stage (parameter W). It contains a registered differentiator with an in/out valid and a one-deep delay register, and is instantiated N times via generate.
- Integrators, decimation counter, warm-up counter and saturation/alignment stay in the top module.

## Test plan
- Continuous all-ones at defaults, DSD_EN_I tied high → after warm-up, every PCM_VALID_O carries PCM_O = 32'h7FFFFF80, spaced exactly 64 cycles apart.
- All-zeros stream → PCM_O = 32'h80000080 on every valid after warm-up.
- Repeating 8'h69 DSD silence, or an alternating 1010 stream → PCM_O = 0 on every valid after warm-up.
- Warm-up and latency check → first PCM_VALID_O exactly 6 cycles after accepted bit 320. No pulse is seen before it.
- Random 1-bit stream with DSD_EN_I toggling randomly at ~50% duty → PCM_O matches a bit-exact CIC reference model fed only the accepted bits.
- Assert NRST_I for one cycle mid-window (bit 30 of a window) → PCM_O and PCM_VALID_O go to 0 immediately. Warm-up restarts, and the first valid follows 320 further accepted bits plus 6 cycles.

Source files
------------

// File: rtl/dsd_pcm_pkg.sv
// Shared DSD/PCM constants and the CIC width helper.
// Used by the DSD-to-PCM decimator and the modulator-side benches.
package dsd_pcm_pkg;

  localparam int DSD_POS = 1;
  localparam int DSD_NEG = -1;

  localparam logic [7:0] DSD_SILENCE = 8'h69;

  function automatic int cic_width(input int n, input int l);
    return n * l + 2;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: out = in - previous in.
// Advances only on a valid input; valid is forwarded one cycle later.
module cic_comb_stage #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly     <= '0;
      out_dat <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_dat - dly;
        dly     <= in_dat;
      end
    end
  end

endmodule

// File: rtl/dsd_cic_decimator.sv
// Order-N CIC decimator turning a 1-bit DSD stream into PCM words.
// Integrators run per accepted bit; combs run at the decimated rate.
module dsd_cic_decimator
  import dsd_pcm_pkg::*;
#(
  parameter int PCM_Bit_Length = 32,
  parameter int CIC_ORDER      = 4,
  parameter int DECIM_LOG2     = 6
) (
  input  logic                      BCLK_I,
  input  logic                      NRST_I,
  input  logic                      DSD_I,
  input  logic                      DSD_EN_I,
  output logic [PCM_Bit_Length-1:0] PCM_O,
  output logic                      PCM_VALID_O
);

  localparam int N  = CIC_ORDER;
  localparam int G  = CIC_ORDER * DECIM_LOG2;
  localparam int W  = cic_width(CIC_ORDER, DECIM_LOG2);
  localparam int SH = PCM_Bit_Length - 1 - G;

  localparam logic signed [W-1:0] LIM  = {2'b00, {G{1'b1}}};
  localparam logic signed [W-1:0] NLIM = -LIM;

  generate
    if (G > PCM_Bit_Length - 1) begin : g_bad_gain
      $error("CIC_ORDER*DECIM_LOG2 exceeds PCM_Bit_Length-1");
    end
    if (N < 1 || N > 6) begin : g_bad_order
      $error("CIC_ORDER must be 1..6");
    end
  endgenerate

  logic signed [W-1:0]    x;
  logic signed [W-1:0]    integ [N];
  logic [DECIM_LOG2-1:0]  cnt;
  logic                   dec_stb;
  logic                   d_vld;
  logic [W-1:0]           d_reg;
  logic [N:0][W-1:0]      c_dat;
  logic [N:0]             c_vld;
  logic [2:0]             warm;
  logic signed [W-1:0]    s;
  logic signed [G:0]      sat;
  logic [PCM_Bit_Length-1:0] pcm_next;

  assign x = DSD_I ? W'(DSD_POS) : W'(DSD_NEG);

  always_ff @(posedge BCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (DSD_EN_I) begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge BCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      cnt     <= '0;
      dec_stb <= 1'b0;
      d_reg   <= '0;
      d_vld   <= 1'b0;
    end else begin
      dec_stb <= DSD_EN_I && (&cnt);
      if (DSD_EN_I) cnt <= cnt + DECIM_LOG2'(1);
      d_vld <= dec_stb;
      if (dec_stb) d_reg <= integ[N-1];
    end
  end

  assign c_dat[0] = d_reg;
  assign c_vld[0] = d_vld;

  generate
    for (genvar k = 0; k < N; k++) begin : g_comb
      cic_comb_stage #(.W(W)) u_comb (
        .clk     (BCLK_I),
        .rst_n   (NRST_I),
        .in_vld  (c_vld[k]),
        .in_dat  (c_dat[k]),
        .out_vld (c_vld[k+1]),
        .out_dat (c_dat[k+1])
      );
    end
  endgenerate

  // Symmetric clamp keeps +full and -full scale mirror images.
  assign s = c_dat[N];

  always_comb begin
    sat = s[G:0];
    if (s > LIM)       sat = LIM[G:0];
    else if (s < NLIM) sat = NLIM[G:0];
  end

  assign pcm_next = PCM_Bit_Length'(sat) <<< SH;

  // The first N comb outputs carry partially filled delay lines.
  always_ff @(posedge BCLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      PCM_O       <= '0;
      PCM_VALID_O <= 1'b0;
      warm        <= '0;
    end else begin
      PCM_VALID_O <= 1'b0;
      if (c_vld[N]) begin
        if (warm == 3'(N)) begin
          PCM_O       <= pcm_next;
          PCM_VALID_O <= 1'b1;
        end else begin
          warm <= warm + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsd_cic_decimator.sv
// Directed bench for the DSD CIC decimator at default parameters.
// A convolution reference predicts every PCM word and its arrival cycle.
module tb_dsd_cic_decimator;
  import dsd_pcm_pkg::*;

  localparam int N   = 4;
  localparam int L   = 6;
  localparam int R   = 64;
  localparam int P   = 32;
  localparam int G   = N * L;
  localparam int SH  = P - 1 - G;
  localparam int HL  = N * (R - 1) + 1;
  localparam longint LIM = (longint'(1) << G) - 1;

  logic          BCLK_I = 1'b0;
  logic          NRST_I;
  logic          DSD_I;
  logic          DSD_EN_I;
  logic [P-1:0]  PCM_O;
  logic          PCM_VALID_O;

  dsd_cic_decimator #(
    .PCM_Bit_Length (P),
    .CIC_ORDER      (N),
    .DECIM_LOG2     (L)
  ) dut (
    .BCLK_I      (BCLK_I),
    .NRST_I      (NRST_I),
    .DSD_I       (DSD_I),
    .DSD_EN_I    (DSD_EN_I),
    .PCM_O       (PCM_O),
    .PCM_VALID_O (PCM_VALID_O)
  );

  always #5 BCLK_I = ~BCLK_I;

  int total = 0;
  int bad   = 0;

  longint       h [HL];
  int           xs [$];
  logic [P-1:0] eq [$];
  int           edue [$];
  int           ncyc = 0;
  int           nacc = 0;
  int           win = 0;
  int           bit_cyc = 0;
  bit           first_seen = 1'b0;
  logic [P-1:0] held = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic void build_h();
    longint tmp [HL];
    int len = 1;
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    repeat (N) begin
      for (int k = 0; k < HL; k++) begin
        tmp[k] = 0;
        for (int t = 0; t < R; t++)
          if (k - t >= 0 && k - t < len) tmp[k] += h[k-t];
      end
      len += R - 1;
      for (int k = 0; k < HL; k++) h[k] = tmp[k];
    end
  endfunction

  function automatic logic [P-1:0] ref_pcm(input int n);
    longint y = 0;
    for (int j = 0; j < HL; j++) begin
      int idx = n - N - j;
      if (idx >= 0) y += h[j] * longint'(xs[idx]);
    end
    if (y > LIM)  y = LIM;
    if (y < -LIM) y = -LIM;
    return P'(y * (longint'(1) << SH));
  endfunction

  function automatic void model_reset();
    xs.delete();
    eq.delete();
    edue.delete();
    nacc = 0;
    win = 0;
    held = '0;
    first_seen = 1'b0;
  endfunction

  function automatic void model_accept(input logic d);
    xs.push_back(d ? DSD_POS : DSD_NEG);
    nacc++;
    if (nacc % R == 0) begin
      win++;
      if (win > N) begin
        eq.push_back(ref_pcm(nacc));
        edue.push_back(ncyc + N + 2);
      end
      if (nacc == (N + 1) * R) bit_cyc = ncyc;
    end
  endfunction

  task automatic observe();
    if (PCM_VALID_O) begin
      if (eq.size() == 0) begin
        check("extra", 64'(PCM_VALID_O), 64'd0);
      end else begin
        check("time", 64'(ncyc), 64'(edue[0]));
        check("pcm", 64'(PCM_O), 64'(eq[0]));
        held = eq[0];
        void'(eq.pop_front());
        void'(edue.pop_front());
        if (!first_seen) begin
          first_seen = 1'b1;
          check("lat", 64'(ncyc - bit_cyc), 64'(N + 2));
        end
      end
    end else if (edue.size() > 0 && edue[0] <= ncyc) begin
      check("miss", 64'(PCM_VALID_O), 64'd1);
      void'(eq.pop_front());
      void'(edue.pop_front());
    end
    check("hold", 64'(PCM_O), 64'(held));
  endtask

  task automatic cyc(input logic d, input logic en);
    DSD_I = d;
    DSD_EN_I = en;
    @(posedge BCLK_I);
    ncyc++;
    if (en && NRST_I) model_accept(d);
    #1;
    observe();
  endtask

  task automatic pulse_reset();
    NRST_I = 1'b0;
    #1;
    model_reset();
    check("arst_pcm", 64'(PCM_O), 64'd0);
    check("arst_vld", 64'(PCM_VALID_O), 64'd0);
    @(posedge BCLK_I);
    ncyc++;
    #1;
    NRST_I = 1'b1;
  endtask

  initial begin
    logic [7:0] sil;
    int run;
    sil = DSD_SILENCE;
    build_h();
    NRST_I = 1'b0;
    DSD_I = 1'b0;
    DSD_EN_I = 1'b0;
    repeat (3) @(posedge BCLK_I);
    #1;
    check("rst_pcm", 64'(PCM_O), 64'd0);
    check("rst_vld", 64'(PCM_VALID_O), 64'd0);
    NRST_I = 1'b1;

    repeat (6 * R) cyc(1'b1, 1'b1);
    check("ones", 64'(PCM_O), 64'h7FFFFF80);
    check("ones_seen", 64'(first_seen), 64'd1);

    repeat (6 * R) cyc(1'b0, 1'b1);
    check("zeros", 64'(PCM_O), 64'h80000080);

    for (int i = 0; i < 6 * R; i++) cyc(sil[7 - (i % 8)], 1'b1);
    check("silence", 64'(PCM_O), 64'd0);

    repeat (6 * R) cyc(1'b1, 1'b1);
    for (int i = 0; i < 6 * R; i++) cyc(1'(i % 2), 1'b1);
    check("alt", 64'(PCM_O), 64'd0);

    repeat (16 * R) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (12) cyc(1'b0, 1'b0);

    run = 0;
    do begin
      cyc(1'b1, 1'b1);
      run++;
    end while (run < 400 || nacc % R != 30);
    check("pre_rst", 64'(PCM_O), 64'h7FFFFF80);

    pulse_reset();
    repeat ((N + 1) * R + 10) cyc(1'b1, 1'b1);
    check("post_seen", 64'(first_seen), 64'd1);
    check("post_rst", 64'(PCM_O), 64'h7FFFFF80);

    repeat (12) cyc(1'b0, 1'b0);
    check("drain", 64'(edue.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
